// File: rtl/poseidon_pkg.sv
// Shared Poseidon constants, ROM layout bases and ARC sequencer state encoding.
package poseidon_pkg;

  localparam int unsigned DW = 256;
  localparam int unsigned T  = 3;
  localparam int unsigned RF = 8;
  localparam int unsigned RP = 57;
  localparam int unsigned RW = 7;
  localparam int unsigned AW = 8;

  localparam int unsigned HalfRf    = RF / 2;
  localparam int unsigned NumRounds = RF + RP;
  // ROM holds early full rounds (T words each), then one word per partial round, then late full.
  localparam int unsigned PartBase  = HalfRf * T;
  localparam int unsigned LateBase  = PartBase + RP;
  localparam int unsigned CW        = $clog2(T + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} arc_state_e;

  function automatic logic is_partial(input logic [RW-1:0] r);
    return (32'(r) >= HalfRf) && (32'(r) < HalfRf + RP);
  endfunction

endpackage

// File: rtl/poseidon_rc_addr_gen.sv
// Maps (round, lane) to the round-constant ROM word address.
module poseidon_rc_addr_gen
  import poseidon_pkg::*;
(
  input  logic [RW-1:0] i_round,
  input  logic [1:0]    i_lane,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] r;
  logic [AW-1:0] k;

  always_comb begin
    r = AW'(i_round);
    k = AW'(i_lane);
    if (r < AW'(HalfRf)) begin
      o_addr = r * AW'(T) + k;
    end else if (r < AW'(HalfRf + RP)) begin
      o_addr = AW'(PartBase) + (r - AW'(HalfRf));
    end else begin
      o_addr = AW'(LateBase) + (r - AW'(HalfRf + RP)) * AW'(T) + k;
    end
  end

endmodule

// File: rtl/poseidon_arc_sched.sv
// Sequences one AddRoundConstant pass: issue lanes to the ARC unit, write results back in order.
module poseidon_arc_sched
  import poseidon_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic [RW-1:0]   i_round,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [1:0]      o_lane_idx,
  input  logic [DW-1:0]   i_lane_x,
  output logic [AW-1:0]   o_rc_addr,
  input  logic [2*DW-1:0] i_rc_data,
  output logic            o_arc_en,
  output logic [DW-1:0]   o_arc_x,
  output logic [DW-1:0]   o_arc_pre,
  output logic [DW-1:0]   o_arc_pos,
  input  logic            i_arc_flag,
  input  logic [DW-1:0]   i_arc_res,
  output logic            o_wb_en,
  output logic [1:0]      o_wb_idx,
  output logic [DW-1:0]   o_wb_data
);

  arc_state_e    state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [1:0]    issue_q, issue_d;
  logic [CW-1:0] res_q, res_d;
  logic [CW-1:0] outst_q, outst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          arc_en_q, arc_en_d;
  logic [DW-1:0] x_q, x_d;

  logic [CW-1:0] lane_cnt;
  logic [AW-1:0] rc_addr;
  logic          run;
  logic          flag_ok;

  poseidon_rc_addr_gen u_addr_gen (
    .i_round (round_q),
    .i_lane  (issue_q),
    .o_addr  (rc_addr)
  );

  assign lane_cnt = is_partial(round_q) ? CW'(1) : CW'(T);
  assign run      = (state_q == StRun);
  // A flag with nothing outstanding is a protocol error and must not touch the state.
  assign flag_ok  = i_arc_flag && (outst_q != '0);

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_lane_idx = run ? issue_q : 2'b0;
  assign o_rc_addr  = run ? rc_addr : '0;
  assign o_arc_en   = arc_en_q;
  assign o_arc_x    = x_q;
  assign o_arc_pre  = arc_en_q ? i_rc_data[2*DW-1:DW] : '0;
  assign o_arc_pos  = arc_en_q ? i_rc_data[DW-1:0] : '0;
  assign o_wb_en    = flag_ok;
  assign o_wb_idx   = flag_ok ? 2'(res_q) : 2'b0;
  assign o_wb_data  = flag_ok ? i_arc_res : '0;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    issue_d  = issue_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = i_arc_flag && !flag_ok;
    arc_en_d = run;
    x_d      = run ? i_lane_x : '0;
    res_d    = res_q + CW'(flag_ok);
    outst_d  = outst_q + CW'(arc_en_q) - CW'(flag_ok);

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (i_round < RW'(NumRounds)) begin
            round_d = i_round;
            issue_d = 2'b0;
            busy_d  = 1'b1;
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        issue_d = issue_q + 2'd1;
        if (CW'(issue_q) == lane_cnt - CW'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Look at next-cycle counts so done follows the last result by one cycle.
        if ((res_d == lane_cnt) && (outst_d == '0)) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
        res_d   = '0;
        issue_d = 2'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= StIdle;
      round_q  <= '0;
      issue_q  <= 2'b0;
      res_q    <= '0;
      outst_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      arc_en_q <= 1'b0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      issue_q  <= issue_d;
      res_q    <= res_d;
      outst_q  <= outst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      arc_en_q <= arc_en_d;
      x_q      <= x_d;
    end
  end

endmodule

// File: tb/tb_poseidon_arc_sched.sv
// Scoreboard bench for poseidon_arc_sched with a random-latency in-order ARC model.
module tb_poseidon_arc_sched;
  import poseidon_pkg::*;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] pre;
    logic [DW-1:0] pos;
  } arc_exp_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] d;
  } wb_exp_t;

  typedef struct {
    int            rel;
    logic [DW-1:0] res;
  } pend_t;

  logic            i_clk;
  logic            i_rstn;
  logic            i_start;
  logic [RW-1:0]   i_round;
  logic            o_busy;
  logic            o_done;
  logic            o_err;
  logic [1:0]      o_lane_idx;
  logic [DW-1:0]   i_lane_x;
  logic [AW-1:0]   o_rc_addr;
  logic [2*DW-1:0] i_rc_data;
  logic            o_arc_en;
  logic [DW-1:0]   o_arc_x;
  logic [DW-1:0]   o_arc_pre;
  logic [DW-1:0]   o_arc_pos;
  logic            i_arc_flag;
  logic [DW-1:0]   i_arc_res;
  logic            o_wb_en;
  logic [1:0]      o_wb_idx;
  logic [DW-1:0]   o_wb_data;

  poseidon_arc_sched dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start    (i_start),
    .i_round    (i_round),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_lane_idx (o_lane_idx),
    .i_lane_x   (i_lane_x),
    .o_rc_addr  (o_rc_addr),
    .i_rc_data  (i_rc_data),
    .o_arc_en   (o_arc_en),
    .o_arc_x    (o_arc_x),
    .o_arc_pre  (o_arc_pre),
    .o_arc_pos  (o_arc_pos),
    .i_arc_flag (i_arc_flag),
    .i_arc_res  (i_arc_res),
    .o_wb_en    (o_wb_en),
    .o_wb_idx   (o_wb_idx),
    .o_wb_data  (o_wb_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  arc_exp_t exp_arc[$];
  wb_exp_t  exp_wb[$];
  int       exp_done = 0;
  int       exp_err = 0;
  int       arc_seen = 0;
  int       last_wb_cyc = 0;
  int       lat_min = 3;
  int       lat_max = 3;
  logic     spur = 1'b0;

  logic [DW-1:0] lanes[4];
  int            addr_tab[NumRounds][T];
  int            ncnt[NumRounds];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_pre(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9e37_79b9 + 32'h7f4a_7c15;
    return {8{w}};
  endfunction

  function automatic logic [DW-1:0] rom_pos(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h85eb_ca6b ^ 32'hc2b2_ae35;
    return {w, 192'h0, ~w, w};
  endfunction

  function automatic logic [DW-1:0] arc_f(input arc_exp_t e);
    return e.x + e.pre + (e.pos << 1);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // Constant ROM: one-cycle synchronous read.
  always @(posedge i_clk) i_rc_data <= {rom_pre(int'(o_rc_addr)), rom_pos(int'(o_rc_addr))};
  assign i_lane_x = lanes[o_lane_idx];

  // ARC unit model: random latency per op, results returned in issue order.
  initial begin
    pend_t pend[$];
    pend_t p;
    int    last_rel;
    int    rel;
    i_arc_flag = 1'b0;
    i_arc_res  = '0;
    last_rel   = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rstn) begin
        pend.delete();
        last_rel   = 0;
        i_arc_flag = 1'b0;
        i_arc_res  = '0;
      end else begin
        if (o_arc_en) begin
          rel = cyc + int'($urandom_range(lat_max, lat_min));
          if (rel <= last_rel) rel = last_rel + 1;
          last_rel = rel;
          p.rel = rel;
          p.res = arc_f('{x: o_arc_x, pre: o_arc_pre, pos: o_arc_pos});
          pend.push_back(p);
        end
        if (pend.size() > 0 && pend[0].rel <= cyc) begin
          p = pend.pop_front();
          i_arc_flag = 1'b1;
          i_arc_res  = p.res;
        end else if (spur) begin
          spur       = 1'b0;
          i_arc_flag = 1'b1;
          i_arc_res  = {8{$urandom}};
        end else begin
          i_arc_flag = 1'b0;
          i_arc_res  = '0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  initial begin
    arc_exp_t a;
    wb_exp_t  w;
    for (int i = 0; i < 4; i++) lanes[i] = {$urandom, $urandom, $urandom, $urandom,
                                            $urandom, $urandom, $urandom, $urandom};
    forever begin
      @(negedge i_clk);
      if (i_rstn) begin
        if (o_arc_en) begin
          arc_seen++;
          if (exp_arc.size() == 0) miss("arc_en_unexpected");
          else begin
            a = exp_arc.pop_front();
            chk("arc_x", o_arc_x, a.x);
            chk("arc_pre", o_arc_pre, a.pre);
            chk("arc_pos", o_arc_pos, a.pos);
          end
        end
        if (o_wb_en) begin
          if (exp_wb.size() == 0) miss("wb_unexpected");
          else begin
            w = exp_wb.pop_front();
            chk("wb_idx", DW'(o_wb_idx), DW'(w.idx));
            chk("wb_data", o_wb_data, w.d);
            if (o_wb_idx != 2'd3) lanes[o_wb_idx] = o_wb_data;
          end
          last_wb_cyc = cyc;
        end
        if (o_done) begin
          if (exp_done == 0) miss("done_unexpected");
          else begin
            exp_done--;
            chk("done_after_last_wb", DW'(cyc), DW'(last_wb_cyc + 1));
            chk("busy_low_at_done", DW'(o_busy), DW'(0));
          end
        end
        if (o_err) begin
          if (exp_err == 0) miss("err_unexpected");
          else exp_err--;
        end
      end
    end
  end

  task automatic start_pass(input int r);
    arc_exp_t a;
    wb_exp_t  w;
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_round = RW'(r);
    if (r < int'(NumRounds)) begin
      for (int k = 0; k < ncnt[r]; k++) begin
        a.x   = lanes[k];
        a.pre = rom_pre(addr_tab[r][k]);
        a.pos = rom_pos(addr_tab[r][k]);
        exp_arc.push_back(a);
        w.idx = k;
        w.d   = arc_f(a);
        exp_wb.push_back(w);
      end
      exp_done++;
    end else begin
      exp_err++;
    end
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk("busy_after_start", DW'(o_busy), DW'(r < int'(NumRounds)));
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (exp_done == 0 && exp_err == 0 && exp_arc.size() == 0 && exp_wb.size() == 0
          && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss(name);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, DW'(o_busy), DW'(0));
    chk({tag, "_done"}, DW'(o_done), DW'(0));
    chk({tag, "_err"}, DW'(o_err), DW'(0));
    chk({tag, "_arc_en"}, DW'(o_arc_en), DW'(0));
    chk({tag, "_arc_x"}, o_arc_x, DW'(0));
    chk({tag, "_wb_en"}, DW'(o_wb_en), DW'(0));
    chk({tag, "_rc_addr"}, DW'(o_rc_addr), DW'(0));
    chk({tag, "_lane_idx"}, DW'(o_lane_idx), DW'(0));
  endtask

  initial begin
    int a;
    int r;
    a = 0;
    for (int rr = 0; rr < int'(NumRounds); rr++) begin
      ncnt[rr] = (rr >= int'(HalfRf) && rr < int'(HalfRf + RP)) ? 1 : int'(T);
      for (int k = 0; k < ncnt[rr]; k++) begin
        addr_tab[rr][k] = a;
        a++;
      end
    end

    i_rstn  = 1'b0;
    i_start = 1'b0;
    i_round = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_quiet("reset");
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Round 0 with fixed latency 3, then a partial and the last full round.
    start_pass(0);
    wait_idle("round0_timeout");
    start_pass(4);
    wait_idle("round4_timeout");
    start_pass(64);
    wait_idle("round64_timeout");

    // Out-of-range round: error pulse, no pass.
    start_pass(65);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("busy_after_bad_round", DW'(o_busy), DW'(0));
    end
    wait_idle("bad_round_err_timeout");

    // Unexpected ARC flag while idle.
    exp_err++;
    spur = 1'b1;
    repeat (4) @(negedge i_clk);
    wait_idle("spurious_flag_err_timeout");

    // Start during RUN is ignored; random latency.
    lat_min = 1;
    lat_max = 10;
    start_pass(2);
    i_start = 1'b1;
    i_round = RW'(5);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_idle("start_in_run_timeout");

    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(70, 0));
      start_pass(r);
      wait_idle("random_pass_timeout");
    end

    // Reset mid-pass after the second issue.
    lat_min  = 5;
    lat_max  = 5;
    arc_seen = 0;
    start_pass(0);
    for (int i = 0; i < 50 && arc_seen < 2; i++) @(negedge i_clk);
    if (arc_seen < 2) miss("second_arc_en_timeout");
    @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    exp_arc.delete();
    exp_wb.delete();
    exp_done = 0;
    exp_err  = 0;
    #1;
    chk_quiet("async_reset");
    @(posedge i_clk);
    #1;
    chk_quiet("reset_edge");
    @(negedge i_clk);
    i_rstn  = 1'b1;
    lat_min = 2;
    lat_max = 2;
    start_pass(1);
    wait_idle("after_reset_timeout");

    chk("left_arc", DW'(exp_arc.size()), DW'(0));
    chk("left_wb", DW'(exp_wb.size()), DW'(0));
    chk("left_done", DW'(exp_done), DW'(0));
    chk("left_err", DW'(exp_err), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
